// File: rtl/instr_mem_fetch.sv
// Instruction memory with a valid/ready fetch port.
// Byte-addressed little-endian store, registered response, programmable
// wait states, fault flag per response and a flush that drops an in-flight fetch.
//
// state  | meaning
// IDLE   | no fetch outstanding, ready to accept
// WAIT   | fetch accepted, wait-state down-counter running
// RESP   | response held on the outputs until the consumer takes it
module instr_mem_fetch #(
  parameter int    XLEN    = 32,
  parameter int    ILEN    = 32,
  parameter int    DEPTH   = 4096,
  parameter int    LATENCY = 0,
  parameter string FILE    = "test.r32i"
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_Req_Valid,
  output logic            o_Req_Ready,
  input  logic [XLEN-1:0] i_Addr,
  input  logic            i_Flush,
  output logic            o_Rsp_Valid,
  input  logic            i_Rsp_Ready,
  output logic [ILEN-1:0] o_Instruction,
  output logic            o_Error
);

  localparam int IB = ILEN / 8;
  localparam int IW = $clog2(DEPTH);
  localparam int CW = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [7:0]      mem [DEPTH];
  logic [1:0]      state;
  logic [CW-1:0]   wait_cnt;
  logic [XLEN-1:0] addr_q;
  logic            accept;
  logic [XLEN-1:0] rd_addr;
  logic            rd_fault;
  logic [IW-1:0]   rd_idx;
  logic [ILEN-1:0] rd_word;

  // A new fetch may enter from IDLE, or from RESP in the same cycle the
  // current response is consumed; flush always blocks acceptance.
  assign o_Req_Ready = !i_Flush && ((state == S_IDLE) || ((state == S_RESP) && i_Rsp_Ready));
  assign accept      = i_Req_Valid && o_Req_Ready;

  // With zero wait states the read happens on the accept edge, so the live
  // address is used; after wait states the latched address is used.
  assign rd_addr  = (state == S_WAIT) ? addr_q : i_Addr;
  // Full-width compare so high address bits fault instead of aliasing.
  assign rd_fault = ((rd_addr % XLEN'(IB)) != '0) || (rd_addr > XLEN'(DEPTH - IB));
  assign rd_idx   = rd_addr[IW-1:0];

  // Little-endian gather of IB bytes; faulting addresses never touch the array.
  always_comb begin
    rd_word = '0;
    if (!rd_fault) begin
      for (int b = 0; b < IB; b++) begin
        rd_word[8*b +: 8] = mem[rd_idx + IW'(b)];
      end
    end
  end

  // Fetch sequencer: accept, count wait states down, present and hold response.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      addr_q        <= '0;
      o_Rsp_Valid   <= 1'b0;
      o_Instruction <= '0;
      o_Error       <= 1'b0;
    end else if (accept) begin
      addr_q <= i_Addr;
      if (LATENCY == 0) begin
        state         <= S_RESP;
        o_Rsp_Valid   <= 1'b1;
        o_Instruction <= rd_word;
        o_Error       <= rd_fault;
      end else begin
        state       <= S_WAIT;
        wait_cnt    <= CW'(LATENCY - 1);
        o_Rsp_Valid <= 1'b0;
      end
    end else begin
      case (state)
        S_WAIT: begin
          if (i_Flush) begin
            state <= S_IDLE;
          end else if (wait_cnt == '0) begin
            state         <= S_RESP;
            o_Rsp_Valid   <= 1'b1;
            o_Instruction <= rd_word;
            o_Error       <= rd_fault;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_RESP: begin
          // Flush drops the response even if the consumer is ready.
          if (i_Flush || i_Rsp_Ready) begin
            state       <= S_IDLE;
            o_Rsp_Valid <= 1'b0;
          end
        end
        S_IDLE: begin
          state <= S_IDLE;
        end
        default: begin
          state       <= S_IDLE;
          o_Rsp_Valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Bench for instr_mem_fetch: one zero-wait instance and one three-wait instance
// share clock and reset; responses are checked against a scoreboard queue.
module tb_instr_mem_fetch;

  logic        clk;
  logic        rst;

  logic        v0, ready0, f0, rv0, rr0, err0;
  logic [31:0] a0, instr0;
  logic        v3, ready3, f3, rv3, rr3, err3;
  logic [31:0] a3, instr3;

  logic [7:0]  img [4096];
  logic [32:0] q0[$];
  logic [32:0] q3[$];

  int n_checks = 0;
  int n_fail   = 0;

  instr_mem_fetch #(.XLEN(32), .ILEN(32), .DEPTH(4096), .LATENCY(0), .FILE("")) dut0 (
    .i_clk(clk), .i_rst(rst), .i_Req_Valid(v0), .o_Req_Ready(ready0), .i_Addr(a0),
    .i_Flush(f0), .o_Rsp_Valid(rv0), .i_Rsp_Ready(rr0), .o_Instruction(instr0), .o_Error(err0)
  );

  instr_mem_fetch #(.XLEN(32), .ILEN(32), .DEPTH(4096), .LATENCY(3), .FILE("")) dut3 (
    .i_clk(clk), .i_rst(rst), .i_Req_Valid(v3), .o_Req_Ready(ready3), .i_Addr(a3),
    .i_Flush(f3), .o_Rsp_Valid(rv3), .i_Rsp_Ready(rr3), .o_Instruction(instr3), .o_Error(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] exp_rsp(input logic [31:0] a);
    int idx;
    if ((a[1:0] != 2'b00) || (a > 32'd4092)) return {1'b1, 32'h0};
    idx = int'(a);
    return {1'b0, img[idx+3], img[idx+2], img[idx+1], img[idx]};
  endfunction

  // Scoreboard for the zero-wait instance: pop on every completed handshake.
  always @(negedge clk) begin
    if (!rst && rv0 && rr0 && !f0) begin
      logic [32:0] e;
      chk("dut0_rsp_expected", 64'(q0.size() != 0), 64'(1));
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("dut0_instr", 64'(instr0), 64'(e[31:0]));
        chk("dut0_error", 64'(err0), 64'(e[32]));
      end
    end
  end

  // Scoreboard for the three-wait instance.
  always @(negedge clk) begin
    if (!rst && rv3 && rr3 && !f3) begin
      logic [32:0] e;
      chk("dut3_rsp_expected", 64'(q3.size() != 0), 64'(1));
      if (q3.size() != 0) begin
        e = q3.pop_front();
        chk("dut3_instr", 64'(instr3), 64'(e[31:0]));
        chk("dut3_error", 64'(err3), 64'(e[32]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addrs [9];
    logic [32:0] e;
    logic        got;

    rst = 1'b1;
    v0 = 1'b0; a0 = '0; f0 = 1'b0; rr0 = 1'b0;
    v3 = 1'b0; a3 = '0; f3 = 1'b0; rr3 = 1'b0;
    for (int i = 0; i < 4096; i++) img[i] = 8'((i * 7 + 3) & 255);
    img[0] = 8'h13; img[1] = 8'h05; img[2] = 8'h10; img[3] = 8'h00;
    for (int i = 0; i < 4096; i++) begin
      dut0.mem[i] = img[i];
      dut3.mem[i] = img[i];
    end

    // Reset state
    @(negedge clk);
    chk("rst_rsp_valid0", 64'(rv0), 64'(0));
    chk("rst_instr0", 64'(instr0), 64'(0));
    chk("rst_error0", 64'(err0), 64'(0));
    chk("rst_rsp_valid3", 64'(rv3), 64'(0));
    chk("rst_req_ready0", 64'(ready0), 64'(1));
    step();
    rst = 1'b0;

    // Zero-wait single fetch from address 0
    v0 = 1'b1; a0 = 32'd0; rr0 = 1'b1;
    q0.push_back(exp_rsp(32'd0));
    step();
    v0 = 1'b0;
    @(negedge clk);
    chk("t1_rsp_valid", 64'(rv0), 64'(1));
    chk("t1_instr", 64'(instr0), 64'(32'h00100513));
    chk("t1_error", 64'(err0), 64'(0));
    step();
    @(negedge clk);
    chk("t1_back_idle", 64'(rv0), 64'(0));

    // Three wait states with the consumer stalled
    e = exp_rsp(32'd4);
    v3 = 1'b1; a3 = 32'd4; rr3 = 1'b0;
    q3.push_back(e);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) v3 = 1'b0;
      @(negedge clk);
      chk("t2_rsp_valid", 64'(rv3), 64'(k >= 4));
      chk("t2_req_ready", 64'(ready3), 64'(0));
      if (k >= 4) chk("t2_instr_stable", 64'(instr3), 64'(e[31:0]));
    end
    step();
    rr3 = 1'b1;
    @(negedge clk);
    chk("t2_ready_on_consume", 64'(ready3), 64'(1));
    step();
    @(negedge clk);
    chk("t2_back_idle", 64'(rv3), 64'(0));

    // Back-to-back zero-wait fetches including fault and boundary addresses
    addrs[0] = 32'd0;    addrs[1] = 32'd4;    addrs[2] = 32'd8;
    addrs[3] = 32'd2;    addrs[4] = 32'd4096; addrs[5] = 32'h8000_0000;
    addrs[6] = 32'd4092; addrs[7] = 32'd4093; addrs[8] = 32'd4095;
    v0 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      a0 = addrs[i];
      q0.push_back(exp_rsp(addrs[i]));
      step();
      @(negedge clk);
      chk("pipe_rsp_valid", 64'(rv0), 64'(1));
      chk("pipe_req_ready", 64'(ready0), 64'(1));
    end
    v0 = 1'b0;
    step();
    @(negedge clk);
    chk("pipe_back_idle", 64'(rv0), 64'(0));

    // Flush in IDLE only blocks acceptance
    step();
    f0 = 1'b1; v0 = 1'b1; a0 = 32'd0;
    #1;
    chk("idle_flush_ready", 64'(ready0), 64'(0));
    step();
    f0 = 1'b0; v0 = 1'b0;
    @(negedge clk);
    chk("idle_flush_no_rsp", 64'(rv0), 64'(0));

    // Flush during wait states drops the fetch
    step();
    v3 = 1'b1; a3 = 32'd8;
    step();
    v3 = 1'b0;
    step();
    f3 = 1'b1;
    @(negedge clk);
    chk("wait_flush_ready", 64'(ready3), 64'(0));
    step();
    f3 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("wait_flush_no_rsp", 64'(rv3), 64'(0));
      chk("wait_flush_idle_ready", 64'(ready3), 64'(1));
      step();
    end
    v3 = 1'b1; a3 = 32'd12;
    q3.push_back(exp_rsp(32'd12));
    step();
    v3 = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rv3) begin
        got = 1'b1;
        break;
      end
    end
    chk("after_flush_rsp_seen", 64'(got), 64'(1));
    step();
    @(negedge clk);
    chk("after_flush_idle", 64'(rv3), 64'(0));

    // Flush in RESP wins over consumer ready and a new request
    step();
    rr3 = 1'b0; v3 = 1'b1; a3 = 32'd16;
    step();
    v3 = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rv3) begin
        got = 1'b1;
        break;
      end
    end
    chk("resp_flush_rsp_seen", 64'(got), 64'(1));
    step();
    f3 = 1'b1; rr3 = 1'b1; v3 = 1'b1; a3 = 32'd20;
    #1;
    chk("resp_flush_ready", 64'(ready3), 64'(0));
    step();
    f3 = 1'b0; v3 = 1'b0; rr3 = 1'b0;
    @(negedge clk);
    chk("resp_flush_dropped", 64'(rv3), 64'(0));
    step();
    @(negedge clk);
    chk("resp_flush_no_new", 64'(rv3), 64'(0));

    // Reset in the middle of wait states
    step();
    v3 = 1'b1; a3 = 32'd0; rr3 = 1'b1;
    step();
    v3 = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid3", 64'(rv3), 64'(0));
    chk("mid_rst_instr3", 64'(instr3), 64'(0));
    chk("mid_rst_error3", 64'(err3), 64'(0));
    chk("mid_rst_instr0", 64'(instr0), 64'(0));
    chk("mid_rst_error0", 64'(err0), 64'(0));
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready3", 64'(ready3), 64'(1));
    chk("post_rst_ready0", 64'(ready0), 64'(1));
    for (int k = 0; k < 6; k++) begin
      step();
      @(negedge clk);
      chk("post_rst_no_rsp", 64'(rv3), 64'(0));
    end

    chk("q0_drained", 64'(q0.size()), 64'(0));
    chk("q3_drained", 64'(q3.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
